atpg_pattern_sequencer: RTL and testbench
=========================================

ATPG_PATTERN_SEQUENCER -- requirements
Module: atpg_pattern_sequencer

Interface
REQ-001 Parameter NPAT, default 6: number of pattern slots applied per run; legal range 1..8.
REQ-002 Parameter INIT_CYC, default 8: cycles the init vector is held per pattern; legal range 1..255.
REQ-003 Parameter CAP_CYC, default 4: cycles the launch vector settles before capture; legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  pattern-table write strobe.
REQ-007 cfg_addr  in  3  pattern slot index.
REQ-008 cfg_wdata  in  9  pattern word: [3:0] init vector {a,b,e,f}; [7:4] launch vector {a,b,e,f}; [8] expected y.
REQ-009 start  in  1  run request, level-sampled.
REQ-010 a_o, b_o, e_o, f_o  out  1 each  registered stimulus to the injection_module under test.
REQ-011 y_i  in  1  response from the injection_module under test.
REQ-012 busy  out  1  high while a run is in progress.
REQ-013 done  out  1  one-cycle pulse at end of run.
REQ-014 pat_idx  out  3  index of the pattern currently applied.
REQ-015 fail_map  out  NPAT  bit k set when pattern k miscompared in the last run.
REQ-016 fail_cnt  out  4  number of miscompared patterns in the last run.

Function
REQ-017 The FSM SHALL have the states IDLE, INIT, LAUNCH, CAPTURE and DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to INIT with pat_idx=0, fail_map=0, fail_cnt=0, and busy=1 from the next cycle.
REQ-019 In INIT, {a_o,b_o,e_o,f_o} SHALL equal init[pat_idx] for exactly INIT_CYC cycles, then the FSM SHALL move to LAUNCH.
REQ-020 In LAUNCH, the outputs SHALL equal launch[pat_idx] for exactly CAP_CYC cycles, then the FSM SHALL move to CAPTURE.
REQ-021 CAPTURE SHALL last one cycle and keep the launch vector driven.
- It SHALL sample y_i.
- If y_i differs from exp[pat_idx], it SHALL set fail_map[pat_idx] and increment fail_cnt.
REQ-022 On leaving CAPTURE:
- if pat_idx==NPAT-1, the FSM SHALL go to DONE;
- otherwise it SHALL increment pat_idx and go to INIT.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, drive outputs 0000, then return to IDLE.
REQ-024 Each pattern SHALL occupy exactly INIT_CYC+CAP_CYC+1 cycles; busy SHALL stay high for NPAT*(INIT_CYC+CAP_CYC+1) cycles.
REQ-025 In IDLE, the outputs SHALL be 0000; fail_map and fail_cnt SHALL hold their last-run values until the next accepted start.
REQ-026 start SHALL be ignored when it is not in IDLE, including in DONE.
REQ-027 cfg_we SHALL write slot cfg_addr only in IDLE.
- Writes while busy or in DONE SHALL be dropped.
- Writes with cfg_addr>=NPAT SHALL be dropped.
REQ-028 When cfg_we and start are both high in IDLE, the write SHALL complete and the run SHALL use the newly written word.
REQ-029 Stimulus outputs SHALL be registered and glitch-free, with at most one vector change per transition.

Reset
REQ-030 rst SHALL force the FSM to IDLE in any state, including mid-run, with:
- busy=0, done=0, pat_idx=0;
- fail_map=0, fail_cnt=0;
- outputs 0000;
- all pattern slots=0.
REQ-031 After reset, the block SHALL accept cfg_we or start on the first cycle rst is low.

Verification
REQ-032 Load slot0=init 0001/launch 1001/exp 1 with a DUT model returning y=1, then start -> a_o..f_o=0001 for 8 cycles, 1001 for 5, fail_map[0]=0, done after 6*13=78 busy cycles.
REQ-033 Load 6 patterns, force y_i=0 and expect 1 on slots 2 and 4 -> fail_map=6'b010100, fail_cnt=2, single done pulse.
REQ-034 Pulse start again at busy cycle 20 and write cfg_addr=1 mid-run -> no restart, table unchanged, total busy still 78 cycles.
REQ-035 Assert rst in LAUNCH of pattern 3 -> next cycle busy=0, outputs 0000, pat_idx=0, fail_cnt=0, slots read back as 0 on the next run.
REQ-036 Write cfg_addr=7 with NPAT=6 -> write ignored; a run with all-zero slots and y_i=0 gives fail_cnt=0.
REQ-037 Write slot0 and assert start in the same IDLE cycle -> the first INIT cycle drives the new init vector.

Source files
------------

// File: rtl/atpg_pattern_sequencer.sv
// ATPG pattern sequencer: applies init/launch/capture patterns to an
// injection module under test and records per-pattern miscompares.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_we/addr/wdata   pattern-table write (IDLE only)
//                       word = {exp y, launch[3:0], init[3:0]}
//   start               run request, sampled in IDLE
//   a_o,b_o,e_o,f_o     registered stimulus vector {a,b,e,f}
//   y_i                 response from the module under test
//   busy, done          run in progress / one-cycle end-of-run pulse
//   pat_idx             pattern currently applied
//   fail_map, fail_cnt  miscompare results of the last run
module atpg_pattern_sequencer #(
  parameter int NPAT     = 6,
  parameter int INIT_CYC = 8,
  parameter int CAP_CYC  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [8:0]      cfg_wdata,
  input  logic            start,
  output logic            a_o,
  output logic            b_o,
  output logic            e_o,
  output logic            f_o,
  input  logic            y_i,
  output logic            busy,
  output logic            done,
  output logic [2:0]      pat_idx,
  output logic [NPAT-1:0] fail_map,
  output logic [3:0]      fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LAUNCH,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_NPAT      = 4'(NPAT);
  localparam logic [2:0] LP_LAST      = 3'(NPAT - 1);
  localparam logic [7:0] LP_INIT_LAST = 8'(INIT_CYC - 1);
  localparam logic [7:0] LP_CAP_LAST  = 8'(CAP_CYC - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [2:0]      w_idx_inc;
  logic [3:0]      r_vec;
  logic [3:0]      w_vec_nxt;
  logic [NPAT-1:0] r_fmap;
  logic [NPAT-1:0] w_fmap_nxt;
  logic [3:0]      r_fcnt;
  logic [3:0]      w_fcnt_nxt;
  logic [8:0]      r_tab [NPAT];
  logic            w_wr_ok;
  logic [8:0]      w_slot0;
  logic [8:0]      w_cur;
  logic [8:0]      w_nxt_word;

  assign w_wr_ok = cfg_we && (r_state == S_IDLE)
                && ({1'b0, cfg_addr} < LP_NPAT);

  // A write to slot 0 in the start cycle must reach the first INIT vector.
  assign w_slot0 = (w_wr_ok && (cfg_addr == 3'd0)) ? cfg_wdata : r_tab[0];

  assign w_idx_inc  = r_idx + 3'd1;
  assign w_cur      = r_tab[r_idx];
  // Only used when r_idx is not the last slot.
  assign w_nxt_word = (r_idx == LP_LAST) ? 9'd0 : r_tab[w_idx_inc];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_vec_nxt   = 4'b0000;
    w_fmap_nxt  = r_fmap;
    w_fcnt_nxt  = r_fcnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = 8'd0;
          w_idx_nxt   = 3'd0;
          w_fmap_nxt  = '0;
          w_fcnt_nxt  = 4'd0;
          w_vec_nxt   = w_slot0[3:0];
        end
      end
      S_INIT: begin
        if (r_cnt == LP_INIT_LAST) begin
          w_state_nxt = S_LAUNCH;
          w_cnt_nxt   = 8'd0;
          w_vec_nxt   = w_cur[7:4];
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          w_vec_nxt = w_cur[3:0];
        end
      end
      S_LAUNCH: begin
        w_vec_nxt = w_cur[7:4];
        if (r_cnt == LP_CAP_LAST) begin
          w_state_nxt = S_CAPTURE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_CAPTURE: begin
        if (y_i != w_cur[8]) begin
          w_fmap_nxt[r_idx] = 1'b1;
          w_fcnt_nxt        = r_fcnt + 4'd1;
        end
        if (r_idx == LP_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = w_idx_inc;
          w_vec_nxt   = w_nxt_word[3:0];
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 3'd0;
      r_vec   <= 4'b0000;
      r_fmap  <= '0;
      r_fcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vec   <= w_vec_nxt;
      r_fmap  <= w_fmap_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPAT; i++) begin
        r_tab[i] <= 9'd0;
      end
    end else if (w_wr_ok) begin
      r_tab[cfg_addr] <= cfg_wdata;
    end
  end

  assign busy     = (r_state == S_INIT) || (r_state == S_LAUNCH)
                 || (r_state == S_CAPTURE);
  assign done     = (r_state == S_DONE);
  assign pat_idx  = r_idx;
  assign fail_map = r_fmap;
  assign fail_cnt = r_fcnt;
  assign {a_o, b_o, e_o, f_o} = r_vec;

endmodule

// File: tb/tb_atpg_pattern_sequencer.sv
// Scoreboard bench for atpg_pattern_sequencer: expected vectors and run
// results are queued by the stimulus and checked by a negedge monitor.
module tb_atpg_pattern_sequencer;

  localparam int NPAT     = 6;
  localparam int INIT_CYC = 8;
  localparam int CAP_CYC  = 4;
  localparam int RUN_LEN  = NPAT * (INIT_CYC + CAP_CYC + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [2:0]      cfg_addr;
  logic [8:0]      cfg_wdata;
  logic            start;
  logic            a_o, b_o, e_o, f_o;
  logic            y_i;
  logic            busy, done;
  logic [2:0]      pat_idx;
  logic [NPAT-1:0] fail_map;
  logic [3:0]      fail_cnt;

  atpg_pattern_sequencer #(
    .NPAT(NPAT), .INIT_CYC(INIT_CYC), .CAP_CYC(CAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start),
    .a_o(a_o), .b_o(b_o), .e_o(e_o), .f_o(f_o), .y_i(y_i),
    .busy(busy), .done(done), .pat_idx(pat_idx),
    .fail_map(fail_map), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int bcnt   = 0;

  logic [8:0] m_tab [NPAT];
  logic [3:0] q_vec [$];
  logic [9:0] q_done [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic y);
    logic [NPAT-1:0] fm;
    logic [3:0]      fc;
    fm = '0;
    fc = 4'd0;
    for (int k = 0; k < NPAT; k++) begin
      repeat (INIT_CYC) q_vec.push_back(m_tab[k][3:0]);
      repeat (CAP_CYC + 1) q_vec.push_back(m_tab[k][7:4]);
      if (m_tab[k][8] != y) begin
        fm[k] = 1'b1;
        fc    = fc + 4'd1;
      end
    end
    q_done.push_back({fm, fc});
  endtask

  task automatic cfg(input logic [2:0] a, input logic [8:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    if (a < NPAT) m_tab[a] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run(input logic y);
    y_i = y;
    push_run(y);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got busy=%0b want done=1", busy);
    end
  endtask

  // Monitor: one vector per busy cycle, one result per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
    end else begin
      if (busy) begin
        bcnt++;
        if (q_vec.size() == 0) begin
          chk("vec_unexpected", 32'(busy), 32'd0);
        end else begin
          chk("vec", 32'({a_o, b_o, e_o, f_o}), 32'(q_vec.pop_front()));
        end
      end
      if (done) begin
        logic [9:0] e;
        n_done++;
        chk("done_vec", 32'({a_o, b_o, e_o, f_o}), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("busy_len", 32'(bcnt), 32'(RUN_LEN));
        bcnt = 0;
        if (q_done.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = q_done.pop_front();
          chk("fail_map", 32'(fail_map), 32'(e[9:4]));
          chk("fail_cnt", 32'(fail_cnt), 32'(e[3:0]));
        end
      end
    end
  end

  initial begin
    int nd;
    logic [8:0] pat [NPAT];
    pat[0] = 9'b0_1010_0101;
    pat[1] = 9'b0_0011_1100;
    pat[2] = 9'b1_1111_0000;
    pat[3] = 9'b0_0110_1001;
    pat[4] = 9'b1_0001_1110;
    pat[5] = 9'b0_1000_0111;
    for (int i = 0; i < NPAT; i++) m_tab[i] = 9'd0;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = 3'd0;
    cfg_wdata = 9'd0;
    start = 1'b0;
    y_i = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(pat_idx), 32'd0);
    chk("rst_fmap", 32'(fail_map), 32'd0);
    chk("rst_fcnt", 32'(fail_cnt), 32'd0);
    chk("rst_vec", 32'({a_o, b_o, e_o, f_o}), 32'd0);
    rst = 1'b0;

    // Single loaded slot, y always 1.
    cfg(3'd0, 9'b1_1001_0001);
    run(1'b1);
    wait_done();
    tick();

    // Six patterns, y=0, expected 1 on slots 2 and 4.
    for (int i = 0; i < NPAT; i++) cfg(3'(i), pat[i]);
    nd = n_done;
    run(1'b0);
    wait_done();
    repeat (4) tick();
    chk("done_pulses", 32'(n_done - nd), 32'd1);
    chk("hold_fmap", 32'(fail_map), 32'b010100);
    chk("hold_fcnt", 32'(fail_cnt), 32'd2);
    chk("idle_vec", 32'({a_o, b_o, e_o, f_o}), 32'd0);

    // Start and write mid-run, then again during DONE: all ignored.
    run(1'b0);
    repeat (19) tick();
    start = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 3'd1;
    cfg_wdata = 9'h1FF;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    wait_done();
    start = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 3'd3;
    cfg_wdata = 9'h1FF;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    tick();
    chk("done_start_idle", 32'(busy), 32'd0);
    run(1'b0);
    wait_done();
    tick();

    // Reset during LAUNCH of pattern 3.
    run(1'b0);
    repeat (47) tick();
    chk("pre_rst_idx", 32'(pat_idx), 32'd3);
    rst = 1'b1;
    q_vec.delete();
    q_done.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NPAT; i++) m_tab[i] = 9'd0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_vec", 32'({a_o, b_o, e_o, f_o}), 32'd0);
    chk("mid_rst_idx", 32'(pat_idx), 32'd0);
    chk("mid_rst_fcnt", 32'(fail_cnt), 32'd0);
    chk("mid_rst_fmap", 32'(fail_map), 32'd0);

    // Out-of-range write right after reset is dropped.
    cfg(3'd7, 9'h1FF);
    run(1'b0);
    wait_done();
    tick();

    // Write slot 0 and start in the same cycle.
    cfg_we = 1'b1;
    cfg_addr = 3'd0;
    cfg_wdata = 9'b0_0110_1011;
    m_tab[0] = 9'b0_0110_1011;
    y_i = 1'b0;
    push_run(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    wait_done();
    repeat (3) tick();

    chk("vec_left", 32'(q_vec.size()), 32'd0);
    chk("done_left", 32'(q_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
